// File: rtl/tl_xing_buffer.sv
// TileLink-UL decoupling buffer between the width widget and the bus crossing.
// Independent circular FIFOs on the A channel (widget -> crossing) and the
// D channel (crossing -> widget). Ready and valid come only from registered
// occupancy, so no combinational valid/ready path crosses the buffer.

module tl_xing_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]    enq_ptr;
   logic [PW-1:0]    deq_ptr;
   logic [CW-1:0]    count;
   logic             enq_fire;
   logic             deq_fire;

   // Depth need not be a power of two, so wrap explicitly at DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO refuses input even while it is draining; no bypass either way.
   assign enq_ready = (count != CW'(DEPTH));
   assign deq_valid = (count != '0);
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;
   assign deq_bits  = storage[deq_ptr];

   // Pointer and occupancy bookkeeping; reset discards everything in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         enq_ptr <= '0;
         deq_ptr <= '0;
         count   <= '0;
      end else begin
         if (enq_fire) enq_ptr <= ptr_inc(enq_ptr);
         if (deq_fire) deq_ptr <= ptr_inc(deq_ptr);
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage carries no reset; contents are only read while valid.
   always_ff @(posedge clock) begin
      if (!reset && enq_fire) storage[enq_ptr] <= enq_bits;
   end

endmodule

module tl_xing_buffer #(
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_a_valid,
   output logic         in_a_ready,
   input  logic [120:0] in_a_bits,
   output logic         out_a_valid,
   input  logic         out_a_ready,
   output logic [120:0] out_a_bits,
   input  logic         out_d_valid,
   output logic         out_d_ready,
   input  logic [82:0]  out_d_bits,
   output logic         in_d_valid,
   input  logic         in_d_ready,
   output logic [82:0]  in_d_bits,
   output logic         idle
);

   tl_xing_fifo #(.WIDTH(121), .DEPTH(A_DEPTH)) u_a_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (in_a_valid),
      .enq_ready (in_a_ready),
      .enq_bits  (in_a_bits),
      .deq_valid (out_a_valid),
      .deq_ready (out_a_ready),
      .deq_bits  (out_a_bits)
   );

   tl_xing_fifo #(.WIDTH(83), .DEPTH(D_DEPTH)) u_d_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (out_d_valid),
      .enq_ready (out_d_ready),
      .enq_bits  (out_d_bits),
      .deq_valid (in_d_valid),
      .deq_ready (in_d_ready),
      .deq_bits  (in_d_bits)
   );

   // Output valids are exactly "count != 0", so idle stays registered-state only.
   assign idle = ~out_a_valid & ~in_d_valid;

endmodule

// File: tb/tb_tl_xing_buffer.sv
// Scoreboard bench for tl_xing_buffer with A_DEPTH=2, D_DEPTH=3.
module tb_tl_xing_buffer;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_a_valid, in_a_ready, out_a_valid, out_a_ready;
   logic [120:0] in_a_bits, out_a_bits;
   logic         out_d_valid, out_d_ready, in_d_valid, in_d_ready;
   logic [82:0]  out_d_bits, in_d_bits;
   logic         idle;

   logic [120:0] a_q[$];
   logic [82:0]  d_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           d_pops = 0;
   logic         a_held = 1'b0, d_held = 1'b0;
   logic [120:0] a_held_bits;
   logic [82:0]  d_held_bits;

   always #5 clock = ~clock;

   tl_xing_buffer #(.A_DEPTH(2), .D_DEPTH(3)) dut (
      .clock(clock), .reset(reset),
      .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits),
      .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_bits(in_d_bits),
      .idle(idle)
   );

   function automatic logic [120:0] mk_a(input logic [63:0] data);
      return {3'd0, 3'd0, 4'd3, 7'h05, 31'h0000_2000, 8'hFF, data, 1'b0};
   endfunction

   function automatic logic [82:0] mk_d(input int src);
      return {3'd1, 2'd0, 4'd3, 7'(src), 1'b0, 1'b0, 64'hD000 + 64'(src), 1'b0};
   endfunction

   // Scoreboard: pop before push so a same-cycle bypass shows up as an unexpected beat.
   always @(negedge clock) begin
      if (reset) begin
         a_q.delete(); d_q.delete();
         a_held = 1'b0; d_held = 1'b0;
      end else begin
         if (a_held) begin
            n_checks++;
            if (!out_a_valid || out_a_bits !== a_held_bits) begin
               n_fail++;
               $display("FAIL a_stall_stable: valid=%b bits=%h, required valid=1 bits=%h", out_a_valid, out_a_bits, a_held_bits);
            end
         end
         a_held = out_a_valid && !out_a_ready;
         a_held_bits = out_a_bits;
         if (d_held) begin
            n_checks++;
            if (!in_d_valid || in_d_bits !== d_held_bits) begin
               n_fail++;
               $display("FAIL d_stall_stable: valid=%b bits=%h, required valid=1 bits=%h", in_d_valid, in_d_bits, d_held_bits);
            end
         end
         d_held = in_d_valid && !in_d_ready;
         d_held_bits = in_d_bits;
         if (out_a_valid && out_a_ready) begin
            n_checks++;
            if (a_q.size() == 0) begin
               n_fail++;
               $display("FAIL a_order: got beat %h, required no beat", out_a_bits);
            end else begin
               logic [120:0] exp_a;
               exp_a = a_q.pop_front();
               if (out_a_bits !== exp_a) begin
                  n_fail++;
                  $display("FAIL a_order: got %h, required %h", out_a_bits, exp_a);
               end
            end
         end
         if (in_d_valid && in_d_ready) begin
            n_checks++;
            d_pops++;
            if (d_q.size() == 0) begin
               n_fail++;
               $display("FAIL d_order: got beat %h, required no beat", in_d_bits);
            end else begin
               logic [82:0] exp_d;
               exp_d = d_q.pop_front();
               if (in_d_bits !== exp_d) begin
                  n_fail++;
                  $display("FAIL d_order: got %h, required %h", in_d_bits, exp_d);
               end
            end
         end
         if (in_a_valid && in_a_ready) a_q.push_back(in_a_bits);
         if (out_d_valid && out_d_ready) d_q.push_back(out_d_bits);
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      n_checks++; if (in_a_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_a_ready: got %b, required 1", in_a_ready); end
      n_checks++; if (out_d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_out_d_ready: got %b, required 1", out_d_ready); end
      n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_a_valid: got %b, required 0", out_a_valid); end
      n_checks++; if (in_d_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_in_d_valid: got %b, required 0", in_d_valid); end
      n_checks++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL reset_idle: got %b, required 1", idle); end
      @(posedge clock); #1;
   endtask

   task automatic test_single_a();
      logic [120:0] exp_a;
      exp_a = {3'd4, 3'd0, 4'd3, 7'h12, 31'h1000_0040, 8'hFF, 64'd0, 1'b0};
      out_a_ready = 1'b1;
      in_a_valid = 1'b1;
      in_a_bits = exp_a;
      @(negedge clock);
      n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_valid: got %b, required 0", out_a_valid); end
      n_checks++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL single_c0_idle: got %b, required 1", idle); end
      @(posedge clock); #1 in_a_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (out_a_valid !== 1'b1) begin n_fail++; $display("FAIL single_c1_valid: got %b, required 1", out_a_valid); end
      n_checks++; if (out_a_bits !== exp_a) begin n_fail++; $display("FAIL single_c1_bits: got %h, required %h", out_a_bits, exp_a); end
      n_checks++; if (idle !== 1'b0)        begin n_fail++; $display("FAIL single_c1_idle: got %b, required 0", idle); end
      @(posedge clock); #1;
      @(negedge clock);
      n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL single_c2_valid: got %b, required 0", out_a_valid); end
      n_checks++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL single_c2_idle: got %b, required 1", idle); end
      @(posedge clock); #1;
   endtask

   task automatic test_backpressure();
      logic exp_rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [63:0] data[3] = '{64'hA, 64'hB, 64'hC};
      int idx = 0;
      logic fire;
      out_a_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc == 4) out_a_ready = 1'b1;
         in_a_valid = (idx < 3);
         in_a_bits = mk_a(data[(idx < 3) ? idx : 2]);
         @(negedge clock);
         n_checks++;
         if (in_a_ready !== exp_rdy[cyc]) begin
            n_fail++;
            $display("FAIL full_in_a_ready cyc%0d: got %b, required %b", cyc, in_a_ready, exp_rdy[cyc]);
         end
         fire = in_a_valid && in_a_ready;
         @(posedge clock); #1;
         if (fire) idx++;
      end
      in_a_valid = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      @(negedge clock);
      n_checks++; if (idx != 3)          begin n_fail++; $display("FAIL full_accepted: got %0d, required 3", idx); end
      n_checks++; if (a_q.size() != 0)   begin n_fail++; $display("FAIL full_drained: got %0d left, required 0", a_q.size()); end
      n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL full_end_valid: got %b, required 0", out_a_valid); end
      @(posedge clock); #1;
   endtask

   task automatic test_stream_d();
      int start_pops = d_pops;
      in_d_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         out_d_valid = 1'b1;
         out_d_bits = mk_d(i);
         @(negedge clock);
         n_checks++;
         if (out_d_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready beat%0d: got %b, required 1", i, out_d_ready); end
         n_checks++;
         if (in_d_valid !== (i != 0)) begin n_fail++; $display("FAIL stream_valid beat%0d: got %b, required %b", i, in_d_valid, (i != 0)); end
         @(posedge clock); #1;
      end
      out_d_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (in_d_valid !== 1'b1) begin n_fail++; $display("FAIL stream_last_valid: got %b, required 1", in_d_valid); end
      @(posedge clock); #1;
      @(negedge clock);
      n_checks++; if (in_d_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b, required 0", in_d_valid); end
      n_checks++; if (d_pops - start_pops != 20) begin n_fail++; $display("FAIL stream_count: got %0d, required 20", d_pops - start_pops); end
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      int sa = 0, sd = 0, cyc = 0;
      logic [127:0] r;
      while ((sa < 1000 || sd < 1000) && cyc < 20000) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_a_valid = (sa < 1000) && ($urandom_range(0, 1) == 1);
         in_a_bits = r[120:0];
         out_a_ready = ($urandom_range(0, 1) == 1);
         out_d_valid = (sd < 1000) && ($urandom_range(0, 1) == 1);
         out_d_bits = r[127:45];
         in_d_ready = ($urandom_range(0, 1) == 1);
         @(negedge clock);
         if (in_a_valid && in_a_ready) sa++;
         if (out_d_valid && out_d_ready) sd++;
         @(posedge clock); #1;
         cyc++;
      end
      n_checks++; if (sa != 1000 || sd != 1000) begin n_fail++; $display("FAIL random_timeout: got a=%0d d=%0d, required 1000 each", sa, sd); end
      in_a_valid = 1'b0; out_d_valid = 1'b0;
      out_a_ready = 1'b1; in_d_ready = 1'b1;
      repeat (8) begin @(posedge clock); #1; end
      @(negedge clock);
      n_checks++; if (a_q.size() != 0) begin n_fail++; $display("FAIL random_a_drain: got %0d left, required 0", a_q.size()); end
      n_checks++; if (d_q.size() != 0) begin n_fail++; $display("FAIL random_d_drain: got %0d left, required 0", d_q.size()); end
      n_checks++; if (idle !== 1'b1)   begin n_fail++; $display("FAIL random_idle: got %b, required 1", idle); end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      out_a_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_a_valid = 1'b1;
         in_a_bits = mk_a(64'hE0 + 64'(k));
         @(posedge clock); #1;
      end
      in_a_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (out_a_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b, required 1", out_a_valid); end
      @(posedge clock); #1;
      reset = 1'b1;
      in_a_valid = 1'b1; in_a_bits = mk_a(64'hEE);
      out_d_valid = 1'b1; out_d_bits = mk_d(99); in_d_ready = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      in_a_valid = 1'b0; out_d_valid = 1'b0; out_a_ready = 1'b1;
      @(negedge clock);
      n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", out_a_valid); end
      n_checks++; if (in_a_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", in_a_ready); end
      n_checks++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL midrst_idle: got %b, required 1", idle); end
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         @(negedge clock);
         n_checks++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_a c%0d: got %b, required 0", k, out_a_valid); end
         n_checks++; if (in_d_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_stale_d c%0d: got %b, required 0", k, in_d_valid); end
      end
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1;
      in_a_valid = 1'b0; in_a_bits = '0; out_a_ready = 1'b0;
      out_d_valid = 1'b0; out_d_bits = '0; in_d_ready = 1'b0;
      test_reset();
      test_single_a();
      test_backpressure();
      test_stream_d();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
